// File: rtl/weight_fetch_sequencer.sv
// Weight-buffer port-0 read sequencer: issues one row read per cycle for a tile
// command and tracks the buffer's fixed read pipeline with a stallable tag pipe.
module weight_fetch_sequencer #(
  parameter int MATRIX_WIDTH = 14,
  parameter int TILE_WIDTH   = 32768,
  parameter int ADDR_WIDTH   = 15,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_rows,
  output logic [ADDR_WIDTH-1:0] buf_address0,
  output logic                  buf_en0,
  output logic                  buf_write_en0,
  output logic                  buf_enable,
  input  logic                  out_ready,
  output logic                  weight_valid,
  output logic [LEN_WIDTH-1:0]  weight_row_idx,
  output logic                  weight_last,
  output logic                  busy,
  output logic                  done
);

  if (MATRIX_WIDTH < 1 || READ_LATENCY < 1 || ADDR_WIDTH < $clog2(TILE_WIDTH)) begin : g_bad_params
    $error("weight_fetch_sequencer: illegal parameter combination");
  end

  localparam logic [ADDR_WIDTH:0] TILE_LIMIT = (ADDR_WIDTH+1)'(TILE_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  k_reg, k_next;
  logic [LEN_WIDTH-1:0]  rows_reg, rows_next;

  logic                  adv;
  logic                  push_valid;
  logic                  push_last;
  logic [LEN_WIDTH-1:0]  push_idx;
  logic                  cmd_ready_c;
  logic                  buf_en0_c;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [ADDR_WIDTH-1:0] addr_wrap;

  logic                  tag_valid_reg [READ_LATENCY];
  logic [LEN_WIDTH-1:0]  tag_idx_reg   [READ_LATENCY];
  logic                  tag_last_reg  [READ_LATENCY];

  assign weight_valid   = tag_valid_reg[READ_LATENCY-1];
  assign weight_row_idx = tag_idx_reg[READ_LATENCY-1];
  assign weight_last    = tag_last_reg[READ_LATENCY-1];

  // A stalled valid row freezes the buffer and the tag pipe together.
  assign adv = ~(weight_valid & ~out_ready);

  // Running address wraps in ADDR_WIDTH+1 bits so non-power-of-2 tiles work.
  assign addr_inc  = {1'b0, addr_reg} + (ADDR_WIDTH+1)'(1);
  assign addr_wrap = (addr_inc >= TILE_LIMIT) ? '0 : addr_inc[ADDR_WIDTH-1:0];

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    k_next      = k_reg;
    rows_next   = rows_reg;
    push_valid  = 1'b0;
    push_idx    = '0;
    push_last   = 1'b0;
    cmd_ready_c = 1'b0;
    buf_en0_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          if (cmd_rows != '0) begin
            addr_next  = cmd_base_addr;
            rows_next  = cmd_rows;
            k_next     = '0;
            state_next = ISSUE;
          end else begin
            state_next = FINISH;
          end
        end
      end
      ISSUE: begin
        if (adv) begin
          buf_en0_c  = 1'b1;
          push_valid = 1'b1;
          push_idx   = k_reg;
          push_last  = (k_reg == rows_reg - LEN_WIDTH'(1));
          addr_next  = addr_wrap;
          k_next     = k_reg + LEN_WIDTH'(1);
          if (push_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (weight_valid && weight_last && out_ready) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      k_reg     <= '0;
      rows_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      k_reg     <= k_next;
      rows_reg  <= rows_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    logic                 valid_in;
    logic [LEN_WIDTH-1:0] idx_in;
    logic                 last_in;
    if (gi == 0) begin : g_head
      assign valid_in = push_valid;
      assign idx_in   = push_idx;
      assign last_in  = push_last;
    end else begin : g_body
      assign valid_in = tag_valid_reg[gi-1];
      assign idx_in   = tag_idx_reg[gi-1];
      assign last_in  = tag_last_reg[gi-1];
    end
    always_ff @(posedge clk) begin
      if (!rst) begin
        tag_valid_reg[gi] <= 1'b0;
        tag_idx_reg[gi]   <= '0;
        tag_last_reg[gi]  <= 1'b0;
      end else if (adv) begin
        tag_valid_reg[gi] <= valid_in;
        tag_idx_reg[gi]   <= idx_in;
        tag_last_reg[gi]  <= last_in;
      end
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign cmd_ready     = rst & cmd_ready_c;
  assign buf_en0       = rst & buf_en0_c;
  assign buf_address0  = (rst && state_reg == ISSUE) ? addr_reg : '0;
  assign buf_write_en0 = 1'b0;
  assign buf_enable    = rst & adv;
  assign busy          = rst & (state_reg != IDLE);
  assign done          = rst & (state_reg == FINISH);

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: a weight-buffer model plus a row-level
// scoreboard of issued addresses, delivered rows, handshakes and done timing.
module tb_weight_fetch_sequencer;
  localparam int AW = 15;
  localparam int LW = 16;
  localparam int TW = 32768;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [LW-1:0] cmd_rows = '0;
  logic [AW-1:0] buf_address0;
  logic          buf_en0, buf_write_en0, buf_enable;
  logic          out_ready = 1'b1;
  logic          weight_valid;
  logic [LW-1:0] weight_row_idx;
  logic          weight_last, busy, done;

  always #5 clk = ~clk;

  weight_fetch_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr), .cmd_rows(cmd_rows),
    .buf_address0(buf_address0), .buf_en0(buf_en0), .buf_write_en0(buf_write_en0),
    .buf_enable(buf_enable), .out_ready(out_ready), .weight_valid(weight_valid),
    .weight_row_idx(weight_row_idx), .weight_last(weight_last), .busy(busy), .done(done)
  );

  function automatic logic [15:0] row_data(int a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  // Weight buffer: registered read on en0, two output stages on buf_enable.
  logic [15:0] ram_q, s1, s2;
  always @(posedge clk) begin
    if (buf_en0) ram_q <= row_data(int'(buf_address0));
    if (buf_enable) begin
      s1 <= ram_q;
      s2 <= s1;
    end
  end

  int checks = 0, errors = 0, cyc = 0;
  bit m_active = 0, done_exp = 0;
  int m_base = 0, m_rows = 0, m_iss = 0, m_del = 0;
  int hs_cyc = 0, first_iss = 0, first_val = 0, done_cyc = 0;
  int vcyc = 0, stall_cnt = 0, accepts = 0, ready_mode = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply out_ready, check this cycle, advance the model.
  task automatic tick();
    bit exp_ready;
    cyc++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = !(vcyc >= 1 && vcyc <= 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    exp_ready = !m_active;
    chk("done", 32'(done), 32'(done_exp));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_active));
    chk("buf_write_en0", 32'(buf_write_en0), 0);
    chk("buf_enable", 32'(buf_enable), 32'(!(weight_valid && !out_ready)));
    if (done_exp) begin
      m_active = 0;
      done_cyc = cyc;
    end
    done_exp = 0;
    if (buf_en0) begin
      if (m_iss == 0) first_iss = cyc;
      chk("issue_in_cmd", 32'(m_active && m_iss < m_rows), 1);
      chk("buf_address0", 32'(buf_address0), 32'((m_base + m_iss) % TW));
      m_iss++;
    end
    if (weight_valid) begin
      if (vcyc == 0) first_val = cyc;
      vcyc++;
      chk("valid_in_cmd", 32'(m_del < m_rows), 1);
      chk("weight_row_idx", 32'(weight_row_idx), 32'(m_del));
      chk("weight_last", 32'(weight_last), 32'(m_del == m_rows - 1));
      chk("read_port0", 32'(s2), 32'(row_data((m_base + m_del) % TW)));
      if (out_ready) begin
        if (m_del == m_rows - 1) done_exp = 1;
        m_del++;
      end else begin
        stall_cnt++;
        chk("stall_en0", 32'(buf_en0), 0);
      end
    end
    if (cmd_valid && exp_ready) begin
      m_active = 1; m_base = int'(cmd_base_addr); m_rows = int'(cmd_rows);
      m_iss = 0; m_del = 0; vcyc = 0; stall_cnt = 0; hs_cyc = cyc; accepts++;
      if (cmd_rows == '0) done_exp = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({cmd_ready, buf_en0, buf_enable, busy, done}), 0);
      chk("rst_weight", 32'({weight_valid, weight_last, weight_row_idx}), 0);
      chk("rst_addr", 32'(buf_address0), 0);
    end
    m_active = 0; done_exp = 0; m_rows = 0; m_iss = 0; m_del = 0; vcyc = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_cmd(int base, int rows);
    int acc0 = accepts;
    int n = 0;
    cmd_base_addr = AW'(base);
    cmd_rows = LW'(rows);
    cmd_valid = 1'b1;
    while (accepts == acc0 && n < 60) begin
      tick();
      n++;
    end
    chk("cmd_accepted", 32'(accepts - acc0), 1);
  endtask

  task automatic finish_cmd(int rows);
    int n = 0;
    cmd_valid = 1'b0;
    cmd_base_addr = AW'($urandom);
    cmd_rows = LW'($urandom);
    while (m_active && n < 600) begin
      tick();
      n++;
    end
    chk("cmd_completed", 32'(m_active), 0);
    chk("rows_issued", 32'(m_iss), 32'(rows));
    chk("rows_delivered", 32'(m_del), 32'(rows));
  endtask

  initial begin
    int a_done;
    @(negedge clk);
    do_reset(2);
    tick();

    // Basic 4-row fetch, no backpressure
    ready_mode = 0;
    start_cmd(16, 4);
    finish_cmd(4);
    chk("t1_issue_latency", 32'(first_iss - hs_cyc), 1);
    chk("t1_valid_latency", 32'(first_val - first_iss), 3);
    chk("t1_done_after_first_valid", 32'(done_cyc - first_val), 4);
    tick();

    // Same command, out_ready low on valid cycles 2-4
    ready_mode = 1;
    start_cmd(16, 4);
    finish_cmd(4);
    chk("t2_stall_cycles", 32'(stall_cnt), 3);
    chk("t2_done_after_first_valid", 32'(done_cyc - first_val), 7);
    ready_mode = 0;
    tick();

    // Address wrap at the top of the buffer
    start_cmd(TW - 2, 4);
    finish_cmd(4);
    tick();

    // Zero-row command
    start_cmd(5, 0);
    finish_cmd(0);
    chk("t4_done_latency", 32'(done_cyc - hs_cyc), 1);
    tick();
    tick();

    // Reset in the middle of issuing an 8-row command
    start_cmd(256, 8);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("t5_issuing_before_reset", 32'(m_iss > 0 && m_iss < 8), 1);
    do_reset(1);
    for (int i = 0; i < 6; i++) tick();
    start_cmd(512, 2);
    finish_cmd(2);
    tick();

    // cmd_valid held high across a whole command
    start_cmd(768, 3);
    start_cmd(1024, 2);
    a_done = done_cyc;
    chk("t6_second_accept_after_done", 32'(hs_cyc - a_done), 1);
    finish_cmd(2);
    tick();

    // Randomized commands with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      int base = $urandom_range(0, TW - 1);
      int rows = $urandom_range(1, 12);
      if (i % 4 == 0) base = TW - 1 - $urandom_range(0, 5);
      start_cmd(base, rows);
      finish_cmd(rows);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
